// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the 8-bit CPU controller: FSM states, instruction classes, opcodes, ALU codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_fsm_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // How the controller has to sequence a given instruction
    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_ALU = 3'd1,
        CLS_LDI = 3'd2,
        CLS_JMP = 3'd3,
        CLS_JZ  = 3'd4,
        CLS_HLT = 3'd5
    } op_class_t;

    // Instruction opcodes (IR[7:4])
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_PASS_B = 3'd4;

    // Instruction field bit positions
    localparam int IR_OP_HI = 7;
    localparam int IR_OP_LO = 4;
    localparam int IR_X_HI  = 3;
    localparam int IR_X_LO  = 2;
    localparam int IR_Y_HI  = 1;
    localparam int IR_Y_LO  = 0;

    // States in which the controller owns an outstanding imem request
    function automatic logic is_fetch_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_FETCH2);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_decode.sv
// Instruction decoder: splits the IR into register fields, sequencing class and ALU opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the IR register.
// Ports: ir_i (instruction byte) -> x_o/y_o (register fields), cls_o (op class), alu_op_o (ALU code).
module cpu_ctrl_fsm_decode
    import cpu_ctrl_fsm_pkg::*;
(
    input  logic [7:0] ir_i,
    output logic [1:0] x_o,
    output logic [1:0] y_o,
    output op_class_t  cls_o,
    output logic [2:0] alu_op_o
);

    logic [3:0] opcode;

    assign opcode = ir_i[IR_OP_HI:IR_OP_LO];
    assign x_o    = ir_i[IR_X_HI:IR_X_LO];
    assign y_o    = ir_i[IR_Y_HI:IR_Y_LO];

    always_comb begin
        cls_o    = CLS_NOP;
        alu_op_o = ALU_ADD;
        case (opcode)
            OP_ADD: begin cls_o = CLS_ALU; alu_op_o = ALU_ADD;    end
            OP_SUB: begin cls_o = CLS_ALU; alu_op_o = ALU_SUB;    end
            OP_AND: begin cls_o = CLS_ALU; alu_op_o = ALU_AND;    end
            OP_OR:  begin cls_o = CLS_ALU; alu_op_o = ALU_OR;     end
            // MOV routes Y through the ALU so it also updates Z
            OP_MOV: begin cls_o = CLS_ALU; alu_op_o = ALU_PASS_B; end
            OP_LDI: cls_o = CLS_LDI;
            OP_JMP: cls_o = CLS_JMP;
            OP_JZ:  cls_o = CLS_JZ;
            OP_HLT: cls_o = CLS_HLT;
            // OP_NOP and the unassigned opcodes 9..E behave as NOP
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller of the 8-bit CPU; owns PC, IR, zero flag and immediate.
// Latency: NOP 2, ALU/MOV 4, LDI 4, JMP/JZ 3 cycles per instruction plus imem wait states.
// Backpressure: imem_req held with a stable imem_addr until imem_ack; the FSM stalls meanwhile.
// Ports: clk/rst_n; imem_req/imem_addr/imem_ack/imem_data fetch handshake; aa/ab/ad/wr RegFile
//        control; alu_op/imm_sel/imm datapath control; alu_zero flag input; halted status.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [1:0]      aa,
    output logic [1:0]      ab,
    output logic [1:0]      ad,
    output logic            wr,
    output logic [2:0]      alu_op,
    output logic            imm_sel,
    output logic [7:0]      imm,
    input  logic            alu_zero,
    output logic            halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      imm_q, imm_d;
    logic            z_q, z_d;
    logic            req_q, req_d;

    logic [1:0]      dec_x;
    logic [1:0]      dec_y;
    op_class_t       dec_cls;
    logic [2:0]      dec_alu_op;
    logic            ack_take;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jmp_target;

    cpu_ctrl_fsm_decode u_decode (
        .ir_i     (ir_q),
        .x_o      (dec_x),
        .y_o      (dec_y),
        .cls_o    (dec_cls),
        .alu_op_o (dec_alu_op)
    );

    // An ack only counts when we are actually requesting
    assign ack_take   = req_q && imem_ack;
    assign pc_inc     = pc_q + PC_W'(1);
    assign jmp_target = PC_W'(imem_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RST_PC;
            ir_q    <= '0;
            imm_q   <= '0;
            z_q     <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            z_q     <= z_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        z_d     = z_q;

        case (state_q)
            ST_FETCH: begin
                if (ack_take) begin
                    ir_d    = imem_data;
                    pc_d    = pc_inc;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (dec_cls)
                    CLS_NOP: state_d = ST_FETCH;
                    CLS_HLT: state_d = ST_HALT;
                    CLS_ALU: state_d = ST_EXEC;
                    default: state_d = ST_FETCH2;
                endcase
            end
            ST_FETCH2: begin
                if (ack_take) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                    case (dec_cls)
                        CLS_LDI: begin
                            imm_d   = imem_data;
                            state_d = ST_WB;
                        end
                        // Jump target wins over the increment on the same edge
                        CLS_JMP: pc_d = jmp_target;
                        CLS_JZ:  if (z_q) pc_d = jmp_target;
                        default: ;
                    endcase
                end
            end
            ST_EXEC: begin
                z_d     = alu_zero;
                state_d = ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // Registered request: asserted in every cycle spent in a fetch state except the
        // very first cycle out of reset, and dropped on the edge that consumes the ack.
        req_d = is_fetch_state(state_d);
    end

    // All outputs come from registered state; the register fields stay valid from
    // DECODE through WB because the IR only changes on a fetch ack.
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign aa        = dec_x;
    assign ab        = dec_y;
    assign ad        = dec_x;
    assign wr        = (state_q == ST_WB);
    assign alu_op    = dec_alu_op;
    assign imm_sel   = (dec_cls == CLS_LDI);
    assign imm       = imm_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with a small instruction-memory responder.
// Latency: n/a.
// Backpressure: responder inserts a programmable number of wait states before each ack.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [1:0] aa;
    logic [1:0] ab;
    logic [1:0] ad;
    logic       wr;
    logic [2:0] alu_op;
    logic       imm_sel;
    logic [7:0] imm;
    logic       alu_zero;
    logic       halted;

    logic [7:0] mem [256];
    int         imem_wait;
    int         wait_cnt;
    int         vec_cnt;
    int         miscmp_cnt;

    cpu_ctrl_fsm #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .aa        (aa),
        .ab        (ab),
        .ad        (ad),
        .wr        (wr),
        .alu_op    (alu_op),
        .imm_sel   (imm_sel),
        .imm       (imm),
        .alu_zero  (alu_zero),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscmp_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; then the memory model answers the current request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= imem_wait) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
            wait_cnt  = 0;
        end else begin
            imem_ack  = 1'b0;
            imem_data = 8'hA5;
            wait_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},     {15'd0, imem_req}, 16'h0);
        chk({tag, "_addr"},    {8'd0, imem_addr}, 16'h0);
        chk({tag, "_wr"},      {15'd0, wr},       16'h0);
        chk({tag, "_aa"},      {14'd0, aa},       16'h0);
        chk({tag, "_ab"},      {14'd0, ab},       16'h0);
        chk({tag, "_ad"},      {14'd0, ad},       16'h0);
        chk({tag, "_aluop"},   {13'd0, alu_op},   16'h0);
        chk({tag, "_imm"},     {8'd0, imm},       16'h0);
        chk({tag, "_immsel"},  {15'd0, imm_sel},  16'h0);
        chk({tag, "_halted"},  {15'd0, halted},   16'h0);
    endtask

    // Several cycles of a stalled fetch: address, request and wr must not move.
    task automatic chk_stall(input string tag, input logic [7:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, {8'd0, imem_addr}, {8'd0, addr});
            chk({tag, "_req"},  {15'd0, imem_req}, 16'h1);
            chk({tag, "_wr"},   {15'd0, wr},       16'h0);
            tick();
        end
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        imem_wait  = 0;
        wait_cnt   = 0;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_data  = 8'h00;
        alu_zero   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h40] = 8'h2A;   // SUB R2,R2
        mem[8'h41] = 8'h80;   // JZ 50 (not taken)
        mem[8'h42] = 8'h50;
        mem[8'h43] = 8'h70;   // JMP FF
        mem[8'h44] = 8'hFF;
        mem[8'hFF] = 8'h00;   // NOP at top of memory

        // Reset state
        ticks(2);
        chk_reset_outs("rst");

        // Run a NOP at 00, then stall the fetch at 01 and reset mid-handshake
        rst_n = 1'b1;
        tick();
        chk("first_req", {15'd0, imem_req}, 16'h1);
        ticks(1);
        imem_wait = 3;
        tick();
        chk("pend_addr", {8'd0, imem_addr}, 16'h01);
        chk("pend_req",  {15'd0, imem_req}, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");

        // Main program: LDI R0,5; LDI R1,3; ADD R0,R1; SUB R2,R2; JZ 40
        mem[0] = 8'h61; mem[1] = 8'h05; mem[2] = 8'h65; mem[3] = 8'h03;
        mem[4] = 8'h11; mem[5] = 8'h2A; mem[6] = 8'h80; mem[7] = 8'h40;
        imem_wait = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_req",  {15'd0, imem_req}, 16'h1);
        chk("restart_addr", {8'd0, imem_addr}, 16'h00);
        ticks(3);
        chk("ldi0_wr",     {15'd0, wr},      16'h1);
        chk("ldi0_ad",     {14'd0, ad},      16'h0);
        chk("ldi0_imm",    {8'd0, imm},      16'h05);
        chk("ldi0_immsel", {15'd0, imm_sel}, 16'h1);
        tick();
        chk("ldi0_wr_pulse", {15'd0, wr}, 16'h0);
        ticks(3);
        chk("ldi1_wr",     {15'd0, wr},      16'h1);
        chk("ldi1_ad",     {14'd0, ad},      16'h1);
        chk("ldi1_imm",    {8'd0, imm},      16'h03);
        chk("ldi1_immsel", {15'd0, imm_sel}, 16'h1);
        ticks(2);
        chk("add_dec_aa", {14'd0, aa}, 16'h0);
        chk("add_dec_ab", {14'd0, ab}, 16'h1);
        tick();
        chk("add_exec_op", {13'd0, alu_op}, 16'h0);
        chk("add_exec_wr", {15'd0, wr},     16'h0);
        tick();
        chk("add_wr",     {15'd0, wr},      16'h1);
        chk("add_ad",     {14'd0, ad},      16'h0);
        chk("add_immsel", {15'd0, imm_sel}, 16'h0);
        chk("add_aluop",  {13'd0, alu_op},  16'h0);
        chk("add_pc",     {8'd0, imem_addr}, 16'h05);
        mem[0] = 8'hF0;       // reached again after the PC wraps
        tick();
        chk("sub_fetch_req",  {15'd0, imem_req}, 16'h1);
        chk("sub_fetch_addr", {8'd0, imem_addr}, 16'h05);
        ticks(2);
        chk("sub_exec_op", {13'd0, alu_op}, 16'h1);
        alu_zero = 1'b1;
        tick();
        chk("sub_wr", {15'd0, wr}, 16'h1);
        chk("sub_ad", {14'd0, ad}, 16'h2);
        ticks(4);
        chk("jz_taken_addr", {8'd0, imem_addr}, 16'h40);
        chk("jz_taken_req",  {15'd0, imem_req}, 16'h1);
        alu_zero = 1'b0;

        // SUB with nonzero result, JZ falls through past its operand
        ticks(6);
        imem_wait = 3;
        tick();
        chk("jz_skip_addr", {8'd0, imem_addr}, 16'h43);

        // Three wait states on every fetch from here on
        chk_stall("wait_jmp", 8'h43, 3);
        ticks(6);
        chk("jmp_addr", {8'd0, imem_addr}, 16'hFF);
        chk_stall("wait_ff", 8'hFF, 3);
        ticks(2);
        chk("wrap_addr", {8'd0, imem_addr}, 16'h00);
        chk("wrap_req",  {15'd0, imem_req}, 16'h1);

        // HLT at 00
        ticks(5);
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", {15'd0, halted},   16'h1);
            chk("halt_req",    {15'd0, imem_req}, 16'h0);
            chk("halt_wr",     {15'd0, wr},       16'h0);
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("haltrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_halt_req",  {15'd0, imem_req}, 16'h1);
        chk("post_halt_addr", {8'd0, imem_addr}, 16'h00);
        chk("post_halt_hlt",  {15'd0, halted},   16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
